// File: rtl/fifo_pkg.sv
// Shared constants and Gray-code helpers for both pointer blocks of the dual-clock FIFO.
package fifo_pkg;

   localparam int ADDRESS_WIDTH = 3;
   localparam int DEPTH         = 1 << ADDRESS_WIDTH;

   function automatic logic [31:0] bin2gray(input logic [31:0] i_bin);
      return i_bin ^ (i_bin >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] i_gray);
      logic [31:0] r_bin;
      r_bin     = 32'd0;
      r_bin[31] = i_gray[31];
      for (int i = 30; i >= 0; i--) begin
         r_bin[i] = r_bin[i + 1] ^ i_gray[i];
      end
      return r_bin;
   endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all Gray bits at or above it.
module fifo_gray2bin #(
   parameter int Width = 4
) (
   input  logic [Width-1:0] i_gray,
   output logic [Width-1:0] o_bin
);

   for (genvar g = 0; g < Width; g++) begin : g_bit
      assign o_bin[g] = ^i_gray[Width-1:g];
   end

endmodule

// File: rtl/fifo_wptr_wfull.sv
// Write-side pointer, full/almost-full flags and fill level of the dual-clock FIFO.
// Optional FIFO_WOVERFLOW_EN adds a sticky overflow flag with a clear input.
module fifo_wptr_wfull
   import fifo_pkg::*;
#(
   parameter int Address_width      = ADDRESS_WIDTH,
   parameter int Almost_full_margin = 2
) (
   input  logic                     Wclk,
   input  logic                     Wrst,
   input  logic                     Winc,
   input  logic [Address_width:0]   W2q_rptr,
`ifdef FIFO_WOVERFLOW_EN
   input  logic                     Wovf_clr,
   output logic                     Woverflow,
`endif
   output logic [Address_width-1:0] Wadder,
   output logic [Address_width:0]   Wptr,
   output logic                     Wfull,
   output logic                     Walmost_full,
   output logic [Address_width:0]   Wfill,
   output logic                     Wwrite_en
);

   localparam int AW         = Address_width;
   localparam int PW         = Address_width + 1;
   localparam int FIFO_DEPTH = 1 << Address_width;
   localparam logic [AW:0] AF_LEVEL = PW'(FIFO_DEPTH - Almost_full_margin);

   logic [AW:0] r_wbin;
   logic [AW:0] r_wptr;
   logic        r_wfull;
   logic        r_walmost_full;
   logic [AW:0] r_wfill;

   logic        w_write_en;
   logic [AW:0] w_wbin_next;
   logic [AW:0] w_wgray_next;
   logic [AW:0] w_rbin;
   logic [AW:0] w_fill_next;
   logic        w_full_next;

   fifo_gray2bin #(.Width(PW)) u_rptr_g2b (
      .i_gray (W2q_rptr),
      .o_bin  (w_rbin)
   );

   // Gating with the reset keeps the memory strobe low while the pointer is held at zero.
   assign w_write_en   = Winc & ~r_wfull & Wrst;
   assign w_wbin_next  = r_wbin + {{AW{1'b0}}, w_write_en};
   assign w_wgray_next = PW'(bin2gray(32'(w_wbin_next)));
   assign w_fill_next  = w_wbin_next - w_rbin;
   assign w_full_next  = (w_wgray_next == {~W2q_rptr[AW:AW-1], W2q_rptr[AW-2:0]});

   // Pointer, flags and fill all update from the next-state values so full sets with no extra latency.
   always_ff @(posedge Wclk or negedge Wrst) begin
      if (!Wrst) begin
         r_wbin         <= '0;
         r_wptr         <= '0;
         r_wfull        <= 1'b0;
         r_walmost_full <= 1'b0;
         r_wfill        <= '0;
      end else begin
         r_wbin         <= w_wbin_next;
         r_wptr         <= w_wgray_next;
         r_wfull        <= w_full_next;
         r_walmost_full <= (w_fill_next >= AF_LEVEL);
         r_wfill        <= w_fill_next;
      end
   end

`ifdef FIFO_WOVERFLOW_EN
   logic r_woverflow;

   // Sticky overflow: a dropped write wins over a clear in the same cycle.
   always_ff @(posedge Wclk or negedge Wrst) begin
      if (!Wrst) begin
         r_woverflow <= 1'b0;
      end else if (Winc & r_wfull) begin
         r_woverflow <= 1'b1;
      end else if (Wovf_clr) begin
         r_woverflow <= 1'b0;
      end else begin
         r_woverflow <= r_woverflow;
      end
   end

   assign Woverflow = r_woverflow;
`endif

   assign Wadder       = r_wbin[AW-1:0];
   assign Wptr         = r_wptr;
   assign Wfull        = r_wfull;
   assign Walmost_full = r_walmost_full;
   assign Wfill        = r_wfill;
   assign Wwrite_en    = w_write_en;

endmodule

// File: tb/tb_fifo_wptr_wfull.sv
// Bench for fifo_wptr_wfull (Address_width=3, Almost_full_margin=2): counter-level model plus directed literals.
module tb_fifo_wptr_wfull;

   logic       Wclk;
   logic       Wrst;
   logic       Winc;
   logic [3:0] W2q_rptr;
   logic [2:0] Wadder;
   logic [3:0] Wptr;
   logic       Wfull;
   logic       Walmost_full;
   logic [3:0] Wfill;
   logic       Wwrite_en;
`ifdef FIFO_WOVERFLOW_EN
   logic       Wovf_clr;
   logic       Woverflow;
`endif

   int checks = 0;
   int errors = 0;

   // Model state: total accepted writes and total reads as plain integers.
   int rd_cnt = 0;
   int m_wr   = 0;
   int m_fill = 0;
   bit m_full = 1'b0;
   bit m_af   = 1'b0;
   bit m_ovf  = 1'b0;

   logic [3:0] prev_wptr = 4'd0;
   bit         prev_ok   = 1'b0;

   fifo_wptr_wfull #(.Address_width(3), .Almost_full_margin(2)) dut (
      .Wclk         (Wclk),
      .Wrst         (Wrst),
      .Winc         (Winc),
      .W2q_rptr     (W2q_rptr),
`ifdef FIFO_WOVERFLOW_EN
      .Wovf_clr     (Wovf_clr),
      .Woverflow    (Woverflow),
`endif
      .Wadder       (Wadder),
      .Wptr         (Wptr),
      .Wfull        (Wfull),
      .Walmost_full (Walmost_full),
      .Wfill        (Wfill),
      .Wwrite_en    (Wwrite_en)
   );

   initial begin
      Wclk = 1'b0;
      forever #5 Wclk = ~Wclk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int gray_of(input int n);
      int b;
      b = n % 16;
      return b ^ (b >> 1);
   endfunction

   task automatic set_rd(input int n);
      rd_cnt   = n;
      W2q_rptr = 4'(gray_of(n));
   endtask

   task automatic step();
      @(posedge Wclk);
      @(negedge Wclk);
      #1;
   endtask

   // Occupancy model: FIFO holds (writes accepted - reads seen); full at 8, almost-full at 6.
   always @(posedge Wclk or negedge Wrst) begin
      if (!Wrst) begin
         m_wr   <= 0;
         m_fill <= 0;
         m_full <= 1'b0;
         m_af   <= 1'b0;
         m_ovf  <= 1'b0;
      end else begin
         int nw;
         nw = m_wr + ((Winc && !m_full) ? 1 : 0);
         m_wr   <= nw;
         m_fill <= nw - rd_cnt;
         m_full <= ((nw - rd_cnt) == 8);
         m_af   <= ((nw - rd_cnt) >= 6);
`ifdef FIFO_WOVERFLOW_EN
         if (Winc && m_full) m_ovf <= 1'b1;
         else if (Wovf_clr)  m_ovf <= 1'b0;
`endif
      end
   end

   // Every-cycle comparison against the model, plus single-bit Gray step check.
   always @(negedge Wclk) begin
      chk("m_wadder",   int'(Wadder),       m_wr % 8);
      chk("m_wptr",     int'(Wptr),         gray_of(m_wr));
      chk("m_wfull",    int'(Wfull),        int'(m_full));
      chk("m_walmost",  int'(Walmost_full), int'(m_af));
      chk("m_wfill",    int'(Wfill),        m_fill);
      chk("m_wwren",    int'(Wwrite_en),    int'(Winc && !m_full && Wrst));
`ifdef FIFO_WOVERFLOW_EN
      chk("m_woverflow", int'(Woverflow),   int'(m_ovf));
`endif
      if (Wrst && prev_ok && (Wptr != prev_wptr))
         chk("wptr_onebit", $countones(Wptr ^ prev_wptr), 1);
      prev_ok   <= Wrst;
      prev_wptr <= Wptr;
   end

   initial begin
      int writes;
      Wrst = 1'b0;
      Winc = 1'b0;
`ifdef FIFO_WOVERFLOW_EN
      Wovf_clr = 1'b0;
`endif
      set_rd(0);
      @(negedge Wclk);
      #1;
      chk("rst_wptr",  int'(Wptr),  0);
      chk("rst_wfill", int'(Wfill), 0);
      chk("rst_wfull", int'(Wfull), 0);
      Wrst = 1'b1;

      // Fill from empty: eight writes with the read pointer parked at 0.
      Winc = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("fill_wadder", int'(Wadder), i);
         step();
         if (i == 4) chk("af_low_at5", int'(Walmost_full), 0);
         if (i == 5) begin
            chk("af_high_at6", int'(Walmost_full), 1);
            chk("fill6",       int'(Wfill),        6);
         end
         if (i == 6) chk("full_low_at7", int'(Wfull), 0);
      end
      chk("full_at8",  int'(Wfull),  1);
      chk("wptr_1100", int'(Wptr),   12);
      chk("fill8",     int'(Wfill),  8);
      chk("wadder_0",  int'(Wadder), 0);

      // Writes while full are dropped.
      for (int i = 0; i < 3; i++) begin
         chk("full_wwren", int'(Wwrite_en), 0);
`ifdef FIFO_WOVERFLOW_EN
         if (i == 2) Wovf_clr = 1'b1;
`endif
         step();
         chk("full_wptr_hold",   int'(Wptr),   12);
         chk("full_wadder_hold", int'(Wadder), 0);
`ifdef FIFO_WOVERFLOW_EN
         chk("ovf_set", int'(Woverflow), 1);
`endif
      end
`ifdef FIFO_WOVERFLOW_EN
      Winc = 1'b0;
      step();
      chk("ovf_clr", int'(Woverflow), 0);
      Wovf_clr = 1'b0;
`endif

      // One read seen: full drops on the next edge, almost-full holds.
      Winc = 1'b0;
      set_rd(1);
      step();
      chk("rd1_wfull", int'(Wfull),        0);
      chk("rd1_wfill", int'(Wfill),        7);
      chk("rd1_waf",   int'(Walmost_full), 1);

      // Write and read-pointer advance on the same edge at fill 7.
      Winc = 1'b1;
      set_rd(2);
      step();
      chk("same_wfill", int'(Wfill), 7);
      chk("same_wfull", int'(Wfull), 0);

      // Wrap: read-only, write+read, write-only pattern for 20 writes.
      writes = 0;
      for (int i = 0; i < 60 && writes < 20; i++) begin
         case (i % 3)
            0: begin Winc = 1'b0; set_rd(rd_cnt + 1); end
            1: begin Winc = 1'b1; set_rd(rd_cnt + 1); writes++; end
            default: begin Winc = 1'b1; writes++; end
         endcase
         step();
      end
      chk("wrap_writes", writes,        20);
      chk("wrap_wadder", int'(Wadder),  5);
      chk("wrap_wptr",   int'(Wptr),    11);
      chk("wrap_wfill",  int'(Wfill),   7);

      // Drain to 4, write to 5, then reset mid-cycle with the write still requested.
      Winc = 1'b0;
      set_rd(rd_cnt + 3);
      step();
      Winc = 1'b1;
      step();
      chk("pre_rst_fill", int'(Wfill), 5);
      #2;
      Wrst = 1'b0;
      #1;
      chk("arst_wadder", int'(Wadder),       0);
      chk("arst_wptr",   int'(Wptr),         0);
      chk("arst_wfull",  int'(Wfull),        0);
      chk("arst_waf",    int'(Walmost_full), 0);
      chk("arst_wfill",  int'(Wfill),        0);
      chk("arst_wwren",  int'(Wwrite_en),    0);
      set_rd(0);
      step();
      Wrst = 1'b1;
      #1;
      chk("post_rst_wadder", int'(Wadder),    0);
      chk("post_rst_wwren",  int'(Wwrite_en), 1);
      step();
      chk("post_rst_wadder1", int'(Wadder), 1);
      chk("post_rst_fill1",   int'(Wfill),  1);
      Winc = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_wptr_wfull.md
Name: fifo_wptr_wfull

Overview:
- Write-side pointer and full-flag block of the dual-clock FIFO. It is the writer counterpart of the read-pointer/empty block.
- Lives entirely in the write clock domain. Inputs are the write request and the read pointer, Gray-coded and already synchronized into this domain.
- Produces the binary RAM write address, the Gray write pointer sent to the read-domain synchronizer, the full and almost-full flags, and the fill level.

Parameters:
- Address_width, 3, RAM address bits; Depth = 2^Address_width.
- Almost_full_margin, 2, Walmost_full asserts when free slots <= this value; legal range 1..Depth-1.

Ports:
- Wclk  input  1  write-domain clock.
- Wrst  input  1  asynchronous, active-low reset.
- Winc  input  1  write request; one entry per cycle while high.
- W2q_rptr  input  Address_width+1  read pointer, Gray code, synchronized to Wclk.
- Wadder  output  Address_width  binary write address to FIFO memory.
- Wptr  output  Address_width+1  registered Gray write pointer, to read-side synchronizer.
- Wfull  output  1  FIFO full, registered.
- Walmost_full  output  1  fill >= Depth - Almost_full_margin, registered.
- Wfill  output  Address_width+1  occupancy as seen from the write side, 0..Depth, registered.
- Wwrite_en  output  1  combinational Winc & ~Wfull; memory write strobe.

Behaviour:
- Reset (Wrst low, async): binary counter = 0, Wptr = 0, Wadder = 0, Wfull = 0, Walmost_full = 0, Wfill = 0. Reset takes effect immediately and may occur mid-burst; the write being performed in that cycle is discarded.
- Wbin_next = Wbin + Wwrite_en, computed at Address_width+1 bits and wrapping modulo 2^(Address_width+1).
- Wgray_next = (Wbin_next >> 1) ^ Wbin_next.
- Each Wclk edge: Wbin <= Wbin_next and Wptr <= Wgray_next. Wadder = Wbin[Address_width-1:0].
- Full: Wfull <= (Wgray_next == {~W2q_rptr[AW:AW-1], W2q_rptr[AW-2:0]}), where AW = Address_width.
  - The flag is set on the same edge that accepts the Depth-th outstanding write. No extra latency.
- Fill: Rbin = gray-to-binary(W2q_rptr); Wfill <= Wbin_next - Rbin, modulo 2^(AW+1).
- Almost-full: Walmost_full <= ((Wbin_next - Rbin) >= Depth - Almost_full_margin).
- Write while full (Winc=1, Wfull=1): ignored. Counter, Wptr and Wadder hold.
- Full deassertion is pessimistic. It drops on the first Wclk edge after W2q_rptr advances, i.e. after the read-side synchronizer latency. This is required and is not a bug.
- Simultaneous write and read-pointer advance in the same cycle: both take effect; fill is unchanged net; flags are recomputed from the next values.
- Wrap-around: the binary counter goes 2^(AW+1)-1 -> 0 and the Gray code stays single-bit-change. Wadder wraps Depth-1 -> 0.

Optional Feature:
- Macro: FIFO_WOVERFLOW_EN.
- Defined:
  - Adds input Wovf_clr (1 bit) and output Woverflow (1 bit, reset 0).
  - Woverflow is a sticky flag. It is set on any edge where Winc & Wfull.
  - It is cleared by Wovf_clr. Set takes priority over clear in the same cycle.
- Undefined: neither port exists; a write while full is silently dropped.

Decomposition:
- Shared package fifo_pkg holds:
  - the default Address_width;
  - the localparam Depth = 1 << Address_width;
  - bin2gray and gray2bin functions, also reused by the read side.
- One sub-module: fifo_gray2bin, a parameterized combinational Gray-to-binary converter (XOR prefix chain). Instantiated here for W2q_rptr and reusable in the read-side block.

Test Plan (Address_width=3, Almost_full_margin=2):
- Reset, hold W2q_rptr=0, assert Winc for 8 cycles.
  - Wadder steps 0..7.
  - Walmost_full rises on the edge of the 6th write (Wfill=6).
  - Wfull rises on the edge of the 8th write.
  - Wptr=4'b1100, Wfill=8.
- Continue Winc=1 while full for 3 cycles.
  - Wptr stays 4'b1100, Wadder stays 0, Wwrite_en=0.
  - With FIFO_WOVERFLOW_EN: Woverflow=1 until Wovf_clr pulses.
- From full, drive W2q_rptr=4'b0001 (1 read), Winc=0.
  - Wfull=0 and Wfill=7 on the next edge; Walmost_full stays 1.
- Wrap test: interleave writes and advancing rptr through 20 writes.
  - Binary counter wraps 15->0.
  - Every Wptr change flips exactly one bit.
  - Wfull never asserts while fill < 8.
- Assert Wrst low mid-burst at fill=5.
  - All outputs are 0 immediately, before the next Wclk edge.
  - After release, the first write targets Wadder=0.
- Winc=1 on the same edge W2q_rptr advances at fill=7: Wfill stays 7 and Wfull stays 0.
